// File: rtl/hdd_presence_monitor_pkg.sv
// Shared defaults, register-map offsets and debounce FSM state type for the HDD presence monitor.
// The optional powered-bay-removal fault logic is built only when HDD_PWR_FAULT_EN is defined.
package hdd_presence_monitor_pkg;

  localparam int HDD_NUM       = 15;
  localparam int HDD_DEB_TICKS = 16;

  // I2C register-map offsets
  localparam logic [7:0] REG_PRESENT   = 8'h00;
  localparam logic [7:0] REG_CHANGE    = 8'h02;
  localparam logic [7:0] REG_INT_MASK  = 8'h04;
  localparam logic [7:0] REG_PWR_FAULT = 8'h06;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } deb_state_t;

endpackage

// File: rtl/hdd_presence_monitor_debounce.sv
// Single-bit 2-flop synchronizer plus STABLE/QUALIFY debounce FSM.
// level is the accepted (active-low) pin level; edge_pulse is high for one cycle after each flip.
module hdd_debounce
  import hdd_presence_monitor_pkg::*;
#(
  parameter int DEB_TICKS = HDD_DEB_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       raw,
  output logic       level,
  output logic       edge_pulse,
  output deb_state_t state
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic [1:0]    sync_q;
  logic          synced;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          edge_q, edge_d;

  assign synced = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    edge_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (synced != level_q) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (synced == level_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (tick) begin
          // The DEB_TICKS-th tick accepts the new level on this edge instead of storing the count
          if (cnt_q == CW'(DEB_TICKS - 1)) begin
            level_d = ~level_q;
            edge_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  assign level      = level_q;
  assign edge_pulse = edge_q;
  assign state      = state_q;

endmodule

// File: rtl/hdd_presence_monitor.sv
// Debounced HDD presence with sticky change flags and a registered active-low interrupt.
// Define HDD_PWR_FAULT_EN to build sticky powered-bay-removal fault flags.
module hdd_presence_monitor
  import hdd_presence_monitor_pkg::*;
#(
  parameter int NUM_HDD   = HDD_NUM,
  parameter int DEB_TICKS = HDD_DEB_TICKS
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic               TICK,
  input  logic [NUM_HDD-1:0] HDD_INSERT_L,
  input  logic [NUM_HDD-1:0] PWR_EN_HDD_L,
  output logic [NUM_HDD-1:0] STS_PRESENT,
  output logic [NUM_HDD-1:0] STS_CHANGE,
  input  logic               CLR_STB,
  input  logic [NUM_HDD-1:0] CLR_MASK,
  input  logic [NUM_HDD-1:0] INT_MASK,
  output logic               INT_L,
  output logic [NUM_HDD-1:0] PWR_FAULT,
  output logic [NUM_HDD-1:0] DEB_BUSY
);

  logic [NUM_HDD-1:0] level_vec;
  logic [NUM_HDD-1:0] edge_vec;
  logic [NUM_HDD-1:0] clr_vec;
  logic [NUM_HDD-1:0] present_q;
  logic [NUM_HDD-1:0] change_q;
  logic [NUM_HDD-1:0] fault_vec;
  logic               int_q;

  for (genvar i = 0; i < NUM_HDD; i++) begin : g_bay
    deb_state_t bay_state;
    hdd_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk        (SYSCLK),
      .rst        (RESET),
      .tick       (TICK),
      .raw        (HDD_INSERT_L[i]),
      .level      (level_vec[i]),
      .edge_pulse (edge_vec[i]),
      .state      (bay_state)
    );
    assign DEB_BUSY[i] = (bay_state == ST_QUALIFY);
  end

  assign clr_vec = CLR_STB ? CLR_MASK : '0;

  // Set terms are ORed after the clear so a coincident edge wins
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      present_q <= '0;
      change_q  <= '0;
      int_q     <= 1'b1;
    end else begin
      present_q <= ~level_vec;
      change_q  <= (change_q & ~clr_vec) | edge_vec;
      int_q     <= ~|((change_q | fault_vec) & ~INT_MASK);
    end
  end

`ifdef HDD_PWR_FAULT_EN
  logic [NUM_HDD-1:0] fault_q;

  // A removal edge has the new accepted level high
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      fault_q <= '0;
    end else begin
      fault_q <= (fault_q & ~clr_vec) | (edge_vec & level_vec & ~PWR_EN_HDD_L);
    end
  end

  assign fault_vec = fault_q;
`else
  logic unused_pwr_en;
  assign unused_pwr_en = ^PWR_EN_HDD_L;
  assign fault_vec     = '0;
`endif

  assign STS_PRESENT = present_q;
  assign STS_CHANGE  = change_q;
  assign INT_L       = int_q;
  assign PWR_FAULT   = fault_vec;

endmodule
